// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing, pixel field layout and pipeline latency.
// Build option: define VGA_ROM_OREG_EN when the pixel ROMs have output registers (latency 2).
package vga_pkg;

  // Default 640x480@60 Hz timing (pixel clock 25 MHz)
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter and colour widths
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned PIX_W  = 9;
  localparam int unsigned COMP_W = 3;
  localparam int unsigned DAC_W  = 4;

  // Pixel layout {R[2:0], G[2:0], B[2:0]}
  localparam int unsigned PIX_R_MSB = 8;
  localparam int unsigned PIX_R_LSB = 6;
  localparam int unsigned PIX_G_MSB = 5;
  localparam int unsigned PIX_G_LSB = 3;
  localparam int unsigned PIX_B_MSB = 2;
  localparam int unsigned PIX_B_LSB = 0;

  // Clocks between the counters and pixel_in from the generators
`ifdef VGA_ROM_OREG_EN
  localparam int unsigned PIPE_LAT = 2;
`else
  localparam int unsigned PIPE_LAT = 1;
`endif

  // Sync/blank bundle carried down the delay line
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  localparam int unsigned SYNC_W = $bits(sync_t);

  // Blanked, sync inactive
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

  // 3-bit colour to 4-bit DAC code, replicating the MSB so full scale stays full scale
  function automatic logic [DAC_W-1:0] expand_comp(input logic [COMP_W-1:0] c);
    return {c, c[COMP_W-1]};
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with async active-low reset to a configurable value.
// last_in_c exposes the value that the final stage will load on the next clock.
module vga_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] last_in_c
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one stage per clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage[i] <= RST_VAL;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

  // Input of the last stage: the raw input when there is only one stage
  if (DEPTH == 1) begin : g_single
    assign last_in_c = din;
  end else begin : g_multi
    assign last_in_c = stage[DEPTH-2];
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: free-running h/v counters, sync/blank delayed to line up
// with pixel-ROM read latency, colour expansion to 4-bit DACs and a frame tick.
// Build option: VGA_ROM_OREG_EN selects a two-clock pixel latency (see vga_pkg).
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned P_H_ACTIVE = H_ACTIVE,
  parameter int unsigned P_H_FP     = H_FP,
  parameter int unsigned P_H_SYNC   = H_SYNC,
  parameter int unsigned P_H_BP     = H_BP,
  parameter int unsigned P_V_ACTIVE = V_ACTIVE,
  parameter int unsigned P_V_FP     = V_FP,
  parameter int unsigned P_V_SYNC   = V_SYNC,
  parameter int unsigned P_V_BP     = V_BP
) (
  input  logic             clk_25MHz,
  input  logic             rst,
  input  logic [PIX_W-1:0] pixel_in,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hsync,
  output logic             vsync,
  output logic [DAC_W-1:0] vga_r,
  output logic [DAC_W-1:0] vga_g,
  output logic [DAC_W-1:0] vga_b,
  output logic             frame_tick
);

  localparam int unsigned LH_TOTAL = P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP;
  localparam int unsigned LV_TOTAL = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP;
  localparam int unsigned HS_BEG   = P_H_ACTIVE + P_H_FP;
  localparam int unsigned HS_END   = HS_BEG + P_H_SYNC;
  localparam int unsigned VS_BEG   = P_V_ACTIVE + P_V_FP;
  localparam int unsigned VS_END   = VS_BEG + P_V_SYNC;

  logic  h_wrap_c;
  logic  v_wrap_c;
  sync_t sync_raw_c;
  sync_t sync_pre_c;
  sync_t sync_dly;

  assign h_wrap_c = (h_cnt == CNT_W'(LH_TOTAL - 1));
  assign v_wrap_c = (v_cnt == CNT_W'(LV_TOTAL - 1));

  // Horizontal/vertical scan counters; v advances on the h wrap
  always_ff @(posedge clk_25MHz or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap_c) begin
      h_cnt <= '0;
      v_cnt <= v_wrap_c ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  // Undelayed sync and display-enable decoded from the counters
  always_comb begin
    sync_raw_c    = SYNC_IDLE;
    sync_raw_c.hs = !((h_cnt >= CNT_W'(HS_BEG)) && (h_cnt < CNT_W'(HS_END)));
    sync_raw_c.vs = !((v_cnt >= CNT_W'(VS_BEG)) && (v_cnt < CNT_W'(VS_END)));
    sync_raw_c.de = (h_cnt < CNT_W'(P_H_ACTIVE)) && (v_cnt < CNT_W'(P_V_ACTIVE));
  end

  // Delay sync/blank by the pixel latency; the last stage drives the pins
  vga_delay_line #(
    .DEPTH   (PIPE_LAT),
    .WIDTH   (SYNC_W),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_dly (
    .clk       (clk_25MHz),
    .rst_n     (rst),
    .din       (sync_raw_c),
    .dout      (sync_dly),
    .last_in_c (sync_pre_c)
  );

  assign hsync = sync_dly.hs;
  assign vsync = sync_dly.vs;

  // Colour register: loaded alongside the final sync stage, blanked outside the visible area
  always_ff @(posedge clk_25MHz or negedge rst) begin
    if (!rst) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else if (sync_pre_c.de) begin
      vga_r <= expand_comp(pixel_in[PIX_R_MSB:PIX_R_LSB]);
      vga_g <= expand_comp(pixel_in[PIX_G_MSB:PIX_G_LSB]);
      vga_b <= expand_comp(pixel_in[PIX_B_MSB:PIX_B_LSB]);
    end else begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end
  end

  // One-clock pulse after the counters reach the first line of vertical blanking
  always_ff @(posedge clk_25MHz or negedge rst) begin
    if (!rst) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= (h_cnt == '0) && (v_cnt == CNT_W'(P_V_ACTIVE));
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: a full-size instance for line-level timing and a
// shrunken-timing instance so whole frames fit in a short run.
module tb_vga_scan_ctrl;

`ifdef VGA_ROM_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // Shrunken timing for the frame-level instance
  localparam int S_HA = 16, S_HFP = 2, S_HS = 3, S_HBP = 3;
  localparam int S_VA = 8,  S_VFP = 1, S_VS = 2, S_VBP = 2;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
  } tim_t;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       tick;
  } obs_t;

  typedef struct {
    int         n;
    logic [8:0] pix;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic [11:0] rgb;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] pixel;

  logic [9:0] h0, v0, h1, v1;
  logic       hs0, vs0, ft0, hs1, vs1, ft1;
  logic [3:0] r0, g0, b0, r1, g1, b1;

  int tests = 0;
  int fails = 0;
  int n;
  int ti;
  tim_t t_big, t_small;
  localparam int NT = 13;
  vec_t tbl [NT];

  always #20 clk = ~clk;

  vga_scan_ctrl u_big (
    .clk_25MHz (clk), .rst (rst_n), .pixel_in (pixel),
    .h_cnt (h0), .v_cnt (v0), .hsync (hs0), .vsync (vs0),
    .vga_r (r0), .vga_g (g0), .vga_b (b0), .frame_tick (ft0)
  );

  vga_scan_ctrl #(
    .P_H_ACTIVE (S_HA), .P_H_FP (S_HFP), .P_H_SYNC (S_HS), .P_H_BP (S_HBP),
    .P_V_ACTIVE (S_VA), .P_V_FP (S_VFP), .P_V_SYNC (S_VS), .P_V_BP (S_VBP)
  ) u_small (
    .clk_25MHz (clk), .rst (rst_n), .pixel_in (pixel),
    .h_cnt (h1), .v_cnt (v1), .hsync (hs1), .vsync (vs1),
    .vga_r (r1), .vga_g (g1), .vga_b (b1), .frame_tick (ft1)
  );

  // 3-bit to 4-bit scaling: 0..7 onto 0..15 with full scale preserved
  function automatic logic [3:0] scale3(input logic [2:0] c);
    int ci;
    ci = int'(c);
    return 4'(ci * 2 + ci / 4);
  endfunction

  // Expected outputs n clocks after reset release, with pix the pixel sampled on that clock
  function automatic obs_t model(input tim_t t, input int nc, input logic [8:0] pix);
    obs_t o;
    int ht, vt, m, hm, vm, pc;
    bit de;
    ht = t.ha + t.hfp + t.hsw + t.hbp;
    vt = t.va + t.vfp + t.vsw + t.vbp;
    o.h = 10'(nc % ht);
    o.v = 10'((nc / ht) % vt);
    m = nc - LAT;
    if (m < 0) begin
      o.hs = 1'b1; o.vs = 1'b1; de = 1'b0;
    end else begin
      hm = m % ht;
      vm = (m / ht) % vt;
      o.hs = !(hm >= t.ha + t.hfp && hm < t.ha + t.hfp + t.hsw);
      o.vs = !(vm >= t.va + t.vfp && vm < t.va + t.vfp + t.vsw);
      de = (hm < t.ha) && (vm < t.va);
    end
    if (de) begin
      o.r = scale3(pix[8:6]); o.g = scale3(pix[5:3]); o.b = scale3(pix[2:0]);
    end else begin
      o.r = 4'h0; o.g = 4'h0; o.b = 4'h0;
    end
    pc = nc - 1;
    o.tick = (nc >= 1) && (pc % ht == 0) && ((pc / ht) % vt == t.va);
    return o;
  endfunction

  function automatic obs_t obs_big();
    return '{h: h0, v: v0, hs: hs0, vs: vs0, r: r0, g: g0, b: b0, tick: ft0};
  endfunction

  function automatic obs_t obs_small();
    return '{h: h1, v: v1, hs: hs1, vs: vs1, r: r1, g: g1, b: b1, tick: ft1};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s n=%0d: got %h expected %h", name, n, got, exp);
    end
  endtask

  task automatic check_reset();
    obs_t r;
    r = '{h: 10'd0, v: 10'd0, hs: 1'b1, vs: 1'b1, r: 4'h0, g: 4'h0, b: 4'h0, tick: 1'b0};
    check("reset_big", 64'(obs_big()), 64'(r));
    check("reset_small", 64'(obs_small()), 64'(r));
  endtask

  // Advance count clocks, checking both instances against the model every clock
  task automatic run_cycles(input int count, input bit echo);
    for (int k = 0; k < count; k++) begin
      int nn;
      bit hit;
      logic [8:0] pix;
      nn  = n + 1;
      hit = 1'b0;
      if (ti < NT && tbl[ti].n == nn) begin
        pix = tbl[ti].pix;
        hit = 1'b1;
      end else if (echo) begin
        pix = (nn - LAT >= 0) ? 9'((nn - LAT) % 800) : 9'h000;
      end else begin
        pix = 9'($urandom);
      end
      pixel = pix;
      @(posedge clk);
      #1;
      n = nn;
      check("model_big", 64'(obs_big()), 64'(model(t_big, n, pix)));
      check("model_small", 64'(obs_small()), 64'(model(t_small, n, pix)));
      if (hit) begin
        check("vector", 64'({h0, v0, hs0, r0, g0, b0}),
              64'({tbl[ti].h, tbl[ti].v, tbl[ti].hs, tbl[ti].rgb}));
        ti++;
      end
    end
  endtask

  initial begin
    t_big   = '{640, 16, 96, 48, 480, 10, 2, 33};
    t_small = '{S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP};

    // Directed line-level vectors for the full-size instance
    tbl[0]  = '{LAT,       9'b111_000_101, 10'(LAT),       10'd0, 1'b1, 12'hF0B};
    tbl[1]  = '{LAT + 1,   9'b111_000_101, 10'(LAT + 1),   10'd0, 1'b1, 12'hF0B};
    tbl[2]  = '{639 + LAT, 9'h1FF,         10'(639 + LAT), 10'd0, 1'b1, 12'hFFF};
    tbl[3]  = '{640 + LAT, 9'h1FF,         10'(640 + LAT), 10'd0, 1'b1, 12'h000};
    tbl[4]  = '{655 + LAT, 9'h1FF,         10'(655 + LAT), 10'd0, 1'b1, 12'h000};
    tbl[5]  = '{656 + LAT, 9'h1FF,         10'(656 + LAT), 10'd0, 1'b0, 12'h000};
    tbl[6]  = '{751 + LAT, 9'h1FF,         10'(751 + LAT), 10'd0, 1'b0, 12'h000};
    tbl[7]  = '{752 + LAT, 9'h1FF,         10'(752 + LAT), 10'd0, 1'b1, 12'h000};
    tbl[8]  = '{799,       9'h1FF,         10'd799,        10'd0, 1'b1, 12'h000};
    tbl[9]  = '{800,       9'h1FF,         10'd0,          10'd1, 1'b1, 12'h000};
    tbl[10] = '{800 + LAT, 9'b010_011_100, 10'(LAT),       10'd1, 1'b1, 12'h469};
    tbl[11] = '{1599,      9'h1FF,         10'd799,        10'd1, 1'b1, 12'h000};
    tbl[12] = '{1600,      9'h1FF,         10'd0,          10'd2, 1'b1, 12'h000};
    ti = 0;
    n  = 0;

    rst_n = 1'b0;
    pixel = 9'h1FF;
    repeat (3) @(posedge clk);
    #1;
    check_reset();

    rst_n = 1'b1;
    check("release_big", 64'(obs_big()), 64'(model(t_big, 0, pixel)));
    check("release_small", 64'(obs_small()), 64'(model(t_small, 0, pixel)));
    run_cycles(2700, 1'b0);

    // Mid-frame asynchronous reset at h=300
    #5;
    rst_n = 1'b0;
    #1;
    check_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset();
    end
    rst_n = 1'b1;
    n = 0;
    check("restart_big", 64'(obs_big()), 64'(model(t_big, 0, pixel)));

    // Echoed column pixels: column 5 is 000_000_101, so only blue is lit
    run_cycles(LAT + 5, 1'b1);
    check("echo_col5", 64'({r0, g0, b0}), 64'(12'h00B));
    run_cycles(995 - LAT, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
